// File: rtl/adder_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_test_pkg
// Description : Shared types and helpers for the pipelined-adder self-checker.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Widest operand the expected-sum helper supports.
    localparam int unsigned c_EXP_W = 16;

    // Number of {a, b, cin} vectors for a given operand width.
    function automatic int unsigned num_vectors(input int unsigned width);
        return 32'd1 << (2 * width + 1);
    endfunction

    function automatic logic [c_EXP_W:0] expected_sum(
        input logic [c_EXP_W-1:0] a,
        input logic [c_EXP_W-1:0] b,
        input logic               cin
    );
        return {1'b0, a} + {1'b0, b} + {{c_EXP_W{1'b0}}, cin};
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_expect_pipe.sv
`default_nettype none
// ============================================================================
// Module      : adder_expect_pipe
// Description : DEPTH-stage delay line of {valid, payload} with sync clear.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_expect_pipe #(
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DW-1:0]    data_q [DEPTH];

    // Only the valids need clearing; payload is ignored while invalid.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        data_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/adder_pipe_checker.sv
`default_nettype none
// ============================================================================
// Module      : adder_pipe_checker
// Description : Exhaustive stimulus and latency-matched checker for a
//               pipelined WIDTH-bit full adder.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_pipe_checker
    import adder_test_pkg::*;
#(
    parameter int WIDTH   = 4,   // 1..15
    parameter int LATENCY = 2    // 1..8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic [WIDTH-1:0]   dut_a_o,
    output logic [WIDTH-1:0]   dut_b_o,
    output logic               dut_cin_o,
    input  logic [WIDTH-1:0]   dut_sum_i,
    input  logic               dut_cout_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [15:0]        err_count_o,
    output logic [2*WIDTH:0]   first_err_vec_o
);

    localparam int VW = 2 * WIDTH + 1;
    localparam int EW = WIDTH + 1;
    localparam int PW = EW + VW;
    localparam logic [VW-1:0] c_LAST_VEC   = VW'(num_vectors(WIDTH) - 1);
    localparam logic [3:0]    c_DRAIN_LAST = 4'(LATENCY - 1);

    state_t         state_q, state_d;
    logic [VW-1:0]  vec_q, vec_d;
    logic [3:0]     drain_q, drain_d;
    logic [15:0]    err_q, err_d;
    logic [VW-1:0]  first_q, first_d;

    logic           w_clr;
    logic           w_stage_valid;
    logic [EW-1:0]  w_exp;
    logic           w_pipe_valid;
    logic [PW-1:0]  w_pipe_data;
    logic [EW-1:0]  w_pipe_exp;
    logic [VW-1:0]  w_pipe_vec;
    logic           w_mismatch;

    // The vector counter doubles as the registered {a, b, cin} drive.
    assign w_exp = EW'(expected_sum(c_EXP_W'(vec_q[VW-1 -: WIDTH]),
                                    c_EXP_W'(vec_q[WIDTH:1]),
                                    vec_q[0]));
    assign w_stage_valid = (state_q == ST_RUN);

    adder_expect_pipe #(
        .DW    (PW),
        .DEPTH (LATENCY)
    ) u_expect_pipe (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (w_clr),
        .valid_i (w_stage_valid),
        .data_i  ({w_exp, vec_q}),
        .valid_o (w_pipe_valid),
        .data_o  (w_pipe_data)
    );

    assign {w_pipe_exp, w_pipe_vec} = w_pipe_data;
    assign w_mismatch = w_pipe_valid && ({dut_cout_i, dut_sum_i} != w_pipe_exp);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        drain_d = drain_q;
        w_clr   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    vec_d   = '0;
                    drain_d = '0;
                    w_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                if (vec_q == c_LAST_VEC) begin
                    state_d = ST_DRAIN;
                    vec_d   = '0;
                    drain_d = '0;
                end else begin
                    vec_d = vec_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == c_DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_d   = err_q;
        first_d = first_q;
        if (w_clr) begin
            err_d   = '0;
            first_d = '0;
        end else if (w_mismatch) begin
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
            if (err_q == 16'd0) begin
                first_d = w_pipe_vec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            drain_q <= '0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign dut_a_o         = vec_q[VW-1 -: WIDTH];
    assign dut_b_o         = vec_q[WIDTH:1];
    assign dut_cin_o       = vec_q[0];
    assign busy_o          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o          = (state_q == ST_DONE);
    assign pass_o          = done_o && (err_q == 16'd0);
    assign err_count_o     = err_q;
    assign first_err_vec_o = first_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_pipe_checker
// Description : Self-checking bench with behavioural adders and outcome model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_pipe_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start0, start1;

    logic [3:0]  a0, b0, sum0;
    logic        cin0, cout0, busy0, done0, pass0;
    logic [15:0] err0;
    logic [8:0]  fev0;

    logic [1:0]  a1, b1, sum1;
    logic        cin1, cout1, busy1, done1, pass1;
    logic [15:0] err1;
    logic [4:0]  fev1;

    int          lat_sel;
    logic [3:0]  stuck_mask;
    logic [4:0]  flip_pat;
    logic [511:0] bad_vec;

    logic [4:0]  m0_s1, m0_s2, m0_s3, m0_out;
    logic [2:0]  m1_s1;

    int n_cmp = 0;
    int n_bad = 0;

    adder_pipe_checker u_dut0 (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start0),
        .dut_a_o         (a0),
        .dut_b_o         (b0),
        .dut_cin_o       (cin0),
        .dut_sum_i       (sum0),
        .dut_cout_i      (cout0),
        .busy_o          (busy0),
        .done_o          (done0),
        .pass_o          (pass0),
        .err_count_o     (err0),
        .first_err_vec_o (fev0)
    );

    adder_pipe_checker #(.WIDTH(2), .LATENCY(1)) u_dut1 (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start1),
        .dut_a_o         (a1),
        .dut_b_o         (b1),
        .dut_cin_o       (cin1),
        .dut_sum_i       (sum1),
        .dut_cout_i      (cout1),
        .busy_o          (busy1),
        .done_o          (done1),
        .pass_o          (pass1),
        .err_count_o     (err1),
        .first_err_vec_o (fev1)
    );

    // Adder under test: selectable latency 2/3, optional corrupted vectors and stuck sum bits.
    always @(posedge clk) begin
        if (rst) begin
            m0_s1 <= 5'd0;
            m0_s2 <= 5'd0;
            m0_s3 <= 5'd0;
            m1_s1 <= 3'd0;
        end else begin
            m0_s1 <= ({1'b0, a0} + {1'b0, b0} + {4'd0, cin0})
                     ^ (bad_vec[{a0, b0, cin0}] ? flip_pat : 5'd0);
            m0_s2 <= m0_s1;
            m0_s3 <= m0_s2;
            m1_s1 <= {1'b0, a1} + {1'b0, b1} + {2'd0, cin1};
        end
    end

    always @* begin
        m0_out = (lat_sel == 3) ? m0_s3 : m0_s2;
        cout0  = m0_out[4];
        sum0   = m0_out[3:0] & ~stuck_mask;
    end

    assign {cout1, sum1} = m1_s1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] true_sum(input int k);
        logic [8:0] v;
        v = 9'(k);
        return {1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'd0, v[0]};
    endfunction

    function automatic logic [4:0] adder_resp(input int k, input logic [3:0] sm);
        logic [4:0] r;
        r = true_sum(k) ^ (bad_vec[k] ? flip_pat : 5'd0);
        r[3:0] = r[3:0] & ~sm;
        return r;
    endfunction

    // Outcome of a full run: a latency-3 adder answers vector k with vector k-1's
    // result (vector 0 is preceded by idle zero inputs).
    function automatic void predict(input int lat, input logic [3:0] sm,
                                    output int errs, output int first);
        int src;
        errs  = 0;
        first = -1;
        for (int k = 0; k < 512; k++) begin
            src = (lat == 3 && k > 0) ? k - 1 : k;
            if (adder_resp(src, sm) !== true_sum(k)) begin
                errs++;
                if (first < 0) first = k;
            end
        end
    endfunction

    task automatic run0(input int dup_at, output int done_edge, output int busy_cyc);
        done_edge = -1;
        busy_cyc  = 0;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        chk("start_edge_busy_done", 32'({busy0, done0}), 32'd2);
        if (busy0) busy_cyc++;
        for (int e = 1; e <= 600 && done_edge < 0; e++) begin
            start0 = (e == dup_at);
            @(posedge clk); #1;
            start0 = 1'b0;
            if (busy0) busy_cyc++;
            if (done0) done_edge = e;
        end
    endtask

    typedef struct {
        int         lat;
        logic [3:0] sm;
        int         nbad;
        int         dup_at;
        int         exp_err;    // -1: take from model
        int         exp_first;  // -1: take from model
    } row_t;

    row_t rows [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  de, bc, perr, pfirst, e_err, e_first;
        bit  quiet;

        rows[0] = '{2, 4'h0, 0, 0,   0,   -1};
        rows[1] = '{2, 4'h1, 0, 0,   256, 1};
        rows[2] = '{3, 4'h0, 0, 0,   -1,  -1};
        rows[3] = '{2, 4'h0, 0, 100, 0,   -1};
        rows[4] = '{2, 4'h0, 4, 0,   -1,  -1};
        rows[5] = '{3, 4'h8, 3, 0,   -1,  -1};
        rows[6] = '{2, 4'h0, 0, 0,   0,   -1};

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        lat_sel = 2; stuck_mask = 4'h0; flip_pat = 5'd0; bad_vec = '0;
        repeat (3) @(posedge clk); #1;
        chk("reset_ctrl_and_drive", 32'({busy0, done0, pass0, a0, b0, cin0}), 32'd0);
        chk("reset_err_count", 32'(err0), 32'd0);
        chk("reset_first_err_vec", 32'(fev0), 32'd0);
        rst = 1'b0;

        for (int r = 0; r < 7; r++) begin
            lat_sel    = rows[r].lat;
            stuck_mask = rows[r].sm;
            bad_vec    = '0;
            flip_pat   = 5'($urandom_range(1, 31));
            for (int i = 0; i < rows[r].nbad; i++) bad_vec[$urandom_range(0, 511)] = 1'b1;
            predict(rows[r].lat, rows[r].sm, perr, pfirst);
            e_err   = (rows[r].exp_err   >= 0) ? rows[r].exp_err   : perr;
            e_first = (rows[r].exp_first >= 0) ? rows[r].exp_first : pfirst;
            repeat ($urandom_range(4, 8)) @(posedge clk); #1;

            run0(rows[r].dup_at, de, bc);
            chk($sformatf("row%0d_done_edge", r), 32'(de), 32'd514);
            chk($sformatf("row%0d_busy_cycles", r), 32'(bc), 32'd514);
            chk($sformatf("row%0d_err_count", r), 32'(err0), 32'(e_err));
            chk($sformatf("row%0d_pass", r), 32'(pass0), 32'(e_err == 0));
            if (e_err != 0)
                chk($sformatf("row%0d_first_err_vec", r), 32'(fev0), 32'(e_first));
            if (rows[r].lat == 3 && rows[r].nbad == 0)
                chk($sformatf("row%0d_lat3_err_nonzero", r), 32'(err0 != 16'd0), 32'd1);
            chk($sformatf("row%0d_drive_zero_in_done", r), 32'({a0, b0, cin0}), 32'd0);
            repeat (3) @(posedge clk); #1;
            chk($sformatf("row%0d_done_held", r), 32'({busy0, done0}), 32'd1);
        end

        // Reset in the middle of a failing run.
        lat_sel = 2; stuck_mask = 4'h1; bad_vec = '0;
        repeat (4) @(posedge clk); #1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (199) @(posedge clk); #1;
        chk("pre_reset_err_nonzero", 32'(err0 != 16'd0), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_ctrl_and_drive", 32'({busy0, done0, pass0, a0, b0, cin0}), 32'd0);
        chk("rst_err_count", 32'(err0), 32'd0);
        chk("rst_first_err_vec", 32'(fev0), 32'd0);
        quiet = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (err0 != 16'd0 || busy0 || done0 || {a0, b0, cin0} != 9'd0) quiet = 1'b0;
        end
        chk("post_reset_quiet", 32'(quiet), 32'd1);
        stuck_mask = 4'h0;
        repeat (4) @(posedge clk); #1;
        run0(0, de, bc);
        chk("after_rst_done_edge", 32'(de), 32'd514);
        chk("after_rst_pass", 32'(pass0), 32'd1);
        chk("after_rst_err_count", 32'(err0), 32'd0);

        // WIDTH=2, LATENCY=1 instance.
        repeat (2) @(posedge clk); #1;
        de = -1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        bc = busy1 ? 1 : 0;
        for (int e = 1; e <= 60 && de < 0; e++) begin
            @(posedge clk); #1;
            if (busy1) bc++;
            if (done1) de = e;
        end
        chk("w2_done_edge", 32'(de), 32'd33);
        chk("w2_busy_cycles", 32'(bc), 32'd33);
        chk("w2_pass", 32'(pass1), 32'd1);
        chk("w2_err_count", 32'(err1), 32'd0);
        chk("w2_drive_zero_in_done", 32'({a1, b1, cin1}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
